// File: rtl/load_store_sequencer.sv
// Byte-serial load/store sequencer between the core and a byte-wide data memory.
// Optional macro LSU_SIGN_EXT_EN: byte loads sign-extend instead of zero-extend.
module load_store_sequencer #(
   parameter int unsigned MEM_DEPTH  = 4096,
   parameter bit          BIG_ENDIAN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic        size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        write_mem,
   input  logic [7:0]  mem_rdata
);

   localparam int unsigned AW = 32;
   localparam int unsigned BW = 2;

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t        state_q;
   logic          we_q;
   logic          size_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [BW-1:0] beat_q;
   logic [BW-1:0] last_q;
   logic [31:0]   load_q;

   logic [BW-1:0] last_c;
   logic [AW:0]   end_c;
   logic          reject_c;
   logic [BW-1:0] beat_next_c;
   logic [4:0]    lane_sh_c;
   logic [31:0]   load_c;
   logic [31:0]   byte_ext_c;

   // Byte k of a store word; a byte store always takes the low byte.
   function automatic logic [7:0] store_byte(input logic [31:0] w, input logic sz,
                                             input logic [BW-1:0] k);
      logic [4:0] sh;
      sh = {(BIG_ENDIAN ? ~k : k), 3'b000};
      return sz ? 8'(w >> sh) : w[7:0];
   endfunction

   // Request decode: beat count and range/alignment rejection, 33-bit to avoid wrap.
   always_comb begin
      last_c   = size ? BW'(3) : BW'(0);
      end_c    = {1'b0, addr} + (AW+1)'(last_c);
      reject_c = (size && (addr[1:0] != 2'b00)) || (end_c >= (AW+1)'(MEM_DEPTH));
   end

   // Load assembly: current beat's byte merged into its lane.
   always_comb begin
      beat_next_c = beat_q + BW'(1);
      lane_sh_c   = {(BIG_ENDIAN ? ~beat_q : beat_q), 3'b000};
      load_c      = (load_q & ~(32'h0000_00FF << lane_sh_c)) | (32'(mem_rdata) << lane_sh_c);
`ifdef LSU_SIGN_EXT_EN
      byte_ext_c  = {{24{mem_rdata[7]}}, mem_rdata};
`else
      byte_ext_c  = {24'h0, mem_rdata};
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         we_q      <= 1'b0;
         size_q    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         beat_q    <= '0;
         last_q    <= '0;
         load_q    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         rdata     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         write_mem <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done <= 1'b0;
               err  <= 1'b0;
               if (req) begin
                  we_q    <= we;
                  size_q  <= size;
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  beat_q  <= '0;
                  last_q  <= last_c;
                  busy    <= 1'b1;
                  if (reject_c) begin
                     state_q <= DONE;
                     done    <= 1'b1;
                     err     <= 1'b1;
                  end else begin
                     state_q   <= XFER;
                     mem_addr  <= addr;
                     mem_wdata <= {24'h0, store_byte(wdata, size, '0)};
                     write_mem <= we;
                  end
               end
            end
            XFER: begin
               if (!we_q) load_q <= load_c;
               if (beat_q == last_q) begin
                  state_q   <= DONE;
                  done      <= 1'b1;
                  write_mem <= 1'b0;
                  if (!we_q) rdata <= size_q ? load_c : byte_ext_c;
               end else begin
                  beat_q    <= beat_next_c;
                  mem_addr  <= addr_q + AW'(beat_next_c);
                  mem_wdata <= {24'h0, store_byte(wdata_q, size_q, beat_next_c)};
                  write_mem <= we_q;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done    <= 1'b0;
               err     <= 1'b0;
               busy    <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_sequencer.sv
// Scoreboard bench for load_store_sequencer: directed transfers with hand-computed
// memory writes and completions, checked by a negedge monitor.
module tb_load_store_sequencer;

   localparam int unsigned DEPTH = 4096;

   logic        clk;
   logic        rst_n;
   logic        req, we, size;
   logic [31:0] addr, wdata;
   logic        busy, done, err, write_mem;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [7:0]  mem_rdata;

   logic [7:0]  mem [DEPTH];

   typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
   typedef struct { logic e; logic chk; logic [31:0] r; } dn_t;

   wr_t wq[$];
   dn_t dq[$];
   wr_t mon_w;
   dn_t mon_d;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] exp_rdata;

   load_store_sequencer #(.MEM_DEPTH(DEPTH), .BIG_ENDIAN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .addr(addr),
      .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .write_mem(write_mem),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[11:0]];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] sx(input logic [7:0] b);
`ifdef LSU_SIGN_EXT_EN
      return {{24{b[7]}}, b};
`else
      return {24'h0, b};
`endif
   endfunction

   // Monitor: memory model plus write and completion scoreboards.
   always @(negedge clk) begin
      if (write_mem) begin
         if (wq.size() == 0) begin
            check("unexpected_write", mem_addr, 32'hFFFF_FFFF);
         end else begin
            mon_w = wq.pop_front();
            check("wr_addr", mem_addr, mon_w.a);
            check("wr_data", mem_wdata, {24'h0, mon_w.d});
         end
         mem[mem_addr[11:0]] = mem_wdata[7:0];
      end
      if (done) begin
         if (dq.size() == 0) begin
            check("unexpected_done", {31'h0, err}, 32'hFFFF_FFFF);
         end else begin
            mon_d = dq.pop_front();
            check("done_err", {31'h0, err}, {31'h0, mon_d.e});
            if (mon_d.chk) check("done_rdata", rdata, mon_d.r);
         end
      end
   end

   task automatic issue(input string nm, input logic w, input logic s, input logic [31:0] a,
                        input logic [31:0] d, input int exp_lat);
      int cyc;
      bit got;
      @(negedge clk);
      req = 1'b1; we = w; size = s; addr = a; wdata = d;
      @(posedge clk);
      #1 req = 1'b0;
      cyc = 0;
      got = 0;
      while (cyc < 20 && !got) begin
         @(negedge clk);
         cyc++;
         if (done) got = 1;
      end
      check({nm, "_latency"}, 32'(cyc), 32'(exp_lat));
   endtask

   task automatic store(input string nm, input logic s, input logic [31:0] a, input logic [31:0] d);
      if (s) begin
         for (int k = 0; k < 4; k++) wq.push_back(wr_t'{a + 32'(k), 8'(d >> (24 - 8*k))});
      end else begin
         wq.push_back(wr_t'{a, d[7:0]});
      end
      dq.push_back(dn_t'{1'b0, 1'b1, exp_rdata});
      issue(nm, 1'b1, s, a, d, s ? 5 : 2);
   endtask

   task automatic load(input string nm, input logic s, input logic [31:0] a, input logic [31:0] r);
      exp_rdata = r;
      dq.push_back(dn_t'{1'b0, 1'b1, r});
      issue(nm, 1'b0, s, a, 32'h0, s ? 5 : 2);
   endtask

   task automatic reject(input string nm, input logic w, input logic s, input logic [31:0] a);
      dq.push_back(dn_t'{1'b1, 1'b0, 32'h0});
      issue(nm, w, s, a, 32'hCAFE_F00D, 1);
   endtask

   initial begin
      int cyc;
      bit got;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = 8'h00;
      mem[12'h040] = 8'h80;
      mem[12'h032] = 8'h5A;
      mem[12'h033] = 8'h5A;
      req = 1'b0; we = 1'b0; size = 1'b0; addr = '0; wdata = '0;
      exp_rdata = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_ctrl", {28'h0, busy, done, err, write_mem}, 32'h0);
      check("reset_mem_addr", mem_addr, 32'h0);
      check("reset_mem_wdata", mem_wdata, 32'h0);
      check("reset_rdata", rdata, 32'h0);
      rst_n = 1'b1;

      store("byte_st_10", 1'b0, 32'h10, 32'h0000_00A5);
      store("word_st_20", 1'b1, 32'h20, 32'h1122_3344);
      load ("word_ld_20", 1'b1, 32'h20, 32'h1122_3344);
      load ("byte_ld_40", 1'b0, 32'h40, sx(8'h80));
      store("byte_st_11", 1'b0, 32'h11, 32'h0000_005C);
      load ("word_ld_10", 1'b1, 32'h10, 32'hA55C_0000);
      reject("rej_word_22", 1'b1, 1'b1, 32'h22);
      reject("rej_word_ffe", 1'b1, 1'b1, 32'(DEPTH - 2));
      reject("rej_byte_1000", 1'b1, 1'b0, 32'(DEPTH));
      reject("rej_word_wrap", 1'b0, 1'b1, 32'hFFFF_FFFC);
      store("word_st_ffc", 1'b1, 32'hFFC, 32'hDEAD_BEEF);
      load ("byte_ld_fff", 1'b0, 32'hFFF, sx(8'hEF));
      load ("word_ld_ffc", 1'b1, 32'hFFC, 32'hDEAD_BEEF);

      // Request held during XFER must be ignored.
      exp_rdata = 32'h1122_3344;
      dq.push_back(dn_t'{1'b0, 1'b1, exp_rdata});
      @(negedge clk);
      req = 1'b1; we = 1'b0; size = 1'b1; addr = 32'h20;
      @(posedge clk);
      #1 we = 1'b1; size = 1'b0; addr = 32'h100; wdata = 32'h77;
      @(negedge clk);
      check("busy_in_xfer", {31'h0, busy}, 32'h1);
      @(negedge clk);
      req = 1'b0;
      cyc = 2;
      got = 0;
      while (cyc < 20 && !got) begin
         @(negedge clk);
         cyc++;
         if (done) got = 1;
      end
      check("ignored_req_latency", 32'(cyc), 32'd5);
      repeat (3) @(negedge clk);
      check("ignored_req_no_write", {24'h0, mem[12'h100]}, 32'h0);
      check("ignored_req_busy", {31'h0, busy}, 32'h0);
      load("after_ignore_byte_ld", 1'b0, 32'h23, sx(8'h44));

      // Reset during beat 2 of a word store.
      wq.push_back(wr_t'{32'h30, 8'hAA});
      wq.push_back(wr_t'{32'h31, 8'hBB});
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 1'b1; addr = 32'h30; wdata = 32'hAABB_CCDD;
      @(posedge clk);
      #1 req = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 check("beat2_addr", mem_addr, 32'h32);
      rst_n = 1'b0;
      #1;
      check("midrst_ctrl", {28'h0, busy, done, err, write_mem}, 32'h0);
      check("midrst_mem_addr", mem_addr, 32'h0);
      check("midrst_mem_wdata", mem_wdata, 32'h0);
      check("midrst_rdata", rdata, 32'h0);
      exp_rdata = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("midrst_no_resume", {31'h0, busy}, 32'h0);
      check("midrst_byte0", {24'h0, mem[12'h030]}, 32'hAA);
      check("midrst_byte1", {24'h0, mem[12'h031]}, 32'hBB);
      check("midrst_byte2", {24'h0, mem[12'h032]}, 32'h5A);
      check("midrst_byte3", {24'h0, mem[12'h033]}, 32'h5A);
      check("midrst_wq_drained", 32'(wq.size()), 32'h0);
      store("post_rst_st_50", 1'b0, 32'h50, 32'h0000_0033);
      load ("post_rst_ld_31", 1'b0, 32'h31, sx(8'hBB));

      repeat (3) @(negedge clk);
      check("done_queue_empty", 32'(dq.size()), 32'h0);
      check("write_queue_empty", 32'(wq.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
